// File: rtl/mon_packet_tx_if.sv
// Parallel packet handshake between the op encoder and the monitor-bus transmitter.
interface mon_packet_tx_if #(
   parameter int unsigned DATA_W = 40
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/mon_packet_tx.sv
// Monitor-bus serial transmitter: start bit, MSB-first payload, stop bit, idle gap.
// One skid-buffer word waits behind the active shift register.
module mon_packet_tx #(
   parameter int unsigned DATA_W = 40,
   parameter int unsigned GAP    = 8
) (
   input  logic            mon_clk,
   input  logic            rst,
   mon_packet_tx_if.slave  in_if,
   output logic            from_mon,
   output logic            busy,
   output logic            tx_done,
   output logic            pending
);
   localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_GAP
   } state_t;

   state_t            state, state_nx;
   logic [DATA_W-1:0] sreg, sreg_nx;
   logic [DATA_W-1:0] buf_data;
   logic              buf_full;
   logic [BW-1:0]     bcnt, bcnt_nx;
   logic [7:0]        gcnt, gcnt_nx;
   logic              load;
   logic              accept;
   logic              from_mon_nx;
   logic              tx_done_nx;

   assign in_if.in_ready = !buf_full;
   assign accept         = in_if.in_valid && !buf_full;
   assign busy           = (state != S_IDLE);
   assign pending        = buf_full;

   // Line and tx_done are registered from the current state, so they trail it by one cycle.
   always_comb begin
      state_nx    = state;
      sreg_nx     = sreg;
      bcnt_nx     = bcnt;
      gcnt_nx     = gcnt;
      load        = 1'b0;
      from_mon_nx = 1'b1;
      tx_done_nx  = 1'b0;
      case (state)
         S_IDLE: begin
            if (buf_full) begin
               load     = 1'b1;
               sreg_nx  = buf_data;
               state_nx = S_START;
            end
         end
         S_START: begin
            from_mon_nx = 1'b0;
            bcnt_nx     = BW'(DATA_W - 1);
            state_nx    = S_DATA;
         end
         S_DATA: begin
            from_mon_nx = sreg[DATA_W-1];
            sreg_nx     = {sreg[DATA_W-2:0], 1'b0};
            if (bcnt == '0) begin
               state_nx = S_STOP;
            end else begin
               bcnt_nx = bcnt - BW'(1);
            end
         end
         S_STOP: begin
            tx_done_nx = 1'b1;
            gcnt_nx    = 8'(GAP);
            state_nx   = S_GAP;
         end
         S_GAP: begin
            gcnt_nx = gcnt - 8'd1;
            if (gcnt == 8'd1) begin
               if (buf_full) begin
                  load     = 1'b1;
                  sreg_nx  = buf_data;
                  state_nx = S_START;
               end else begin
                  state_nx = S_IDLE;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge mon_clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         sreg     <= '0;
         bcnt     <= '0;
         gcnt     <= '0;
         from_mon <= 1'b1;
         tx_done  <= 1'b0;
      end else begin
         state    <= state_nx;
         sreg     <= sreg_nx;
         bcnt     <= bcnt_nx;
         gcnt     <= gcnt_nx;
         from_mon <= from_mon_nx;
         tx_done  <= tx_done_nx;
      end
   end

   // An accept wins over a drain so a word arriving on the load edge is never dropped.
   always_ff @(posedge mon_clk or posedge rst) begin
      if (rst) begin
         buf_data <= '0;
         buf_full <= 1'b0;
      end else if (accept) begin
         buf_data <= in_if.in_data;
         buf_full <= 1'b1;
      end else if (load) begin
         buf_full <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mon_packet_tx.sv
// Self-checking bench for mon_packet_tx: receiver model plus scoreboard, directed timing sequences.
module tb_mon_packet_tx;
   localparam int unsigned DW = 40;

   logic mon_clk = 1'b0;
   logic rst     = 1'b1;
   logic from_mon, busy, tx_done, pending;
   logic from_mon1, busy1, tx_done1, pending1;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;

   logic [DW-1:0] sb[$];
   int unsigned   starts[$];

   mon_packet_tx_if #(.DATA_W(DW)) bus0 ();
   mon_packet_tx_if #(.DATA_W(DW)) bus1 ();

   mon_packet_tx #(.DATA_W(DW), .GAP(8)) u_dut (
      .mon_clk (mon_clk),
      .rst     (rst),
      .in_if   (bus0),
      .from_mon(from_mon),
      .busy    (busy),
      .tx_done (tx_done),
      .pending (pending)
   );

   mon_packet_tx #(.DATA_W(DW), .GAP(1)) u_dut_g1 (
      .mon_clk (mon_clk),
      .rst     (rst),
      .in_if   (bus1),
      .from_mon(from_mon1),
      .busy    (busy1),
      .tx_done (tx_done1),
      .pending (pending1)
   );

   always #5 mon_clk = ~mon_clk;
   always @(posedge mon_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Receiver model sampling the line mid-bit.
   int unsigned   rx_st  = 0;
   int unsigned   rx_cnt = 0;
   logic [DW-1:0] rx_sh  = '0;
   always @(negedge mon_clk) begin
      if (rst) begin
         rx_st = 0;
      end else begin
         case (rx_st)
            0: begin
               check("idle_tx_done", 64'(tx_done), 64'(0));
               if (from_mon == 1'b0) begin
                  rx_st  = 1;
                  rx_cnt = 0;
                  starts.push_back(cyc);
               end
            end
            1: begin
               rx_sh = {rx_sh[DW-2:0], from_mon};
               rx_cnt++;
               if (rx_cnt == DW) rx_st = 2;
            end
            default: begin
               check("rx_stop_bit", 64'(from_mon), 64'(1));
               check("rx_tx_done", 64'(tx_done), 64'(1));
               if (sb.size() == 0) check("rx_unexpected_packet", 64'(1), 64'(0));
               else check("rx_word", 64'(rx_sh), 64'(sb.pop_front()));
               rx_st = 0;
            end
         endcase
      end
   end

   task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] e, output int unsigned acc);
      int unsigned n = 0;
      @(negedge mon_clk);
      bus0.in_valid = 1'b1;
      bus0.in_data  = d;
      while (!bus0.in_ready && n < 300) begin
         @(negedge mon_clk);
         n++;
      end
      if (!bus0.in_ready) begin
         check("send_timeout", 64'(0), 64'(1));
         bus0.in_valid = 1'b0;
         acc = 0;
      end else begin
         acc = cyc + 1;
         sb.push_back(e);
         @(posedge mon_clk);
      end
   endtask

   task automatic wait_drain();
      int unsigned n = 0;
      while ((sb.size() != 0 || busy) && n < 600) begin
         @(negedge mon_clk);
         n++;
      end
      check("drain_timeout", 64'(sb.size() != 0 || busy), 64'(0));
   endtask

   typedef struct {
      logic [DW-1:0] data;
      int unsigned   idle;
      logic [DW-1:0] exp;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int unsigned   ta, tb, tc, t1, n;
      logic [DW-1:0] w;

      tbl[0] = '{40'hFF_FFFF_FFFF, 3, 40'hFF_FFFF_FFFF};
      tbl[1] = '{40'h00_0000_0000, 0, 40'h00_0000_0000};
      tbl[2] = '{40'hAA_5555_AAAA, 0, 40'hAA_5555_AAAA};
      tbl[3] = '{40'h80_0000_0001, 7, 40'h80_0000_0001};
      tbl[4] = '{40'h01_2345_6789, 1, 40'h01_2345_6789};
      tbl[5] = '{40'h7F_FFFF_FFFE, 0, 40'h7F_FFFF_FFFE};

      bus0.in_valid = 1'b0;
      bus0.in_data  = '0;
      bus1.in_valid = 1'b0;
      bus1.in_data  = '0;

      // Reset values and quiet idle line
      repeat (3) @(negedge mon_clk);
      check("rst_from_mon", 64'(from_mon), 64'(1));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_in_ready", 64'(bus0.in_ready), 64'(1));
      check("rst_tx_done", 64'(tx_done), 64'(0));
      check("rst_pending", 64'(pending), 64'(0));
      #2 rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge mon_clk);
         check("idle_from_mon", 64'(from_mon), 64'(1));
         check("idle_busy", 64'(busy), 64'(0));
         check("idle_in_ready", 64'(bus0.in_ready), 64'(1));
      end

      // Single packet, exact bit timing relative to accept edge T
      w = 40'hC0_1234_5678;
      @(negedge mon_clk);
      check("single_in_ready", 64'(bus0.in_ready), 64'(1));
      bus0.in_valid = 1'b1;
      bus0.in_data  = w;
      sb.push_back(w);
      @(negedge mon_clk);
      bus0.in_valid = 1'b0;
      bus0.in_data  = '1;
      check("T_pending", 64'(pending), 64'(1));
      check("T_busy", 64'(busy), 64'(0));
      check("T_in_ready", 64'(bus0.in_ready), 64'(0));
      @(negedge mon_clk);
      check("T1_pending", 64'(pending), 64'(0));
      check("T1_busy", 64'(busy), 64'(1));
      check("T1_from_mon", 64'(from_mon), 64'(1));
      @(negedge mon_clk);
      check("T2_start_bit", 64'(from_mon), 64'(0));
      for (int i = 0; i < 40; i++) begin
         @(negedge mon_clk);
         check("single_data_bit", 64'(from_mon), 64'(w[39-i]));
         check("single_no_tx_done", 64'(tx_done), 64'(0));
      end
      @(negedge mon_clk);
      check("T43_stop", 64'(from_mon), 64'(1));
      check("T43_tx_done", 64'(tx_done), 64'(1));
      for (int i = 0; i < 7; i++) begin
         @(negedge mon_clk);
         check("gap_line_high", 64'(from_mon), 64'(1));
         check("gap_busy", 64'(busy), 64'(1));
      end
      @(negedge mon_clk);
      check("T51_busy_low", 64'(busy), 64'(0));
      check("T51_from_mon", 64'(from_mon), 64'(1));
      wait_drain();

      // Table-driven vectors through the scoreboard
      for (int i = 0; i < 6; i++) begin
         for (int unsigned k = 0; k < tbl[i].idle; k++) begin
            @(negedge mon_clk);
            bus0.in_valid = 1'b0;
            bus0.in_data  = {$urandom, $urandom};
         end
         send(tbl[i].data, tbl[i].exp, ta);
      end
      @(negedge mon_clk);
      bus0.in_valid = 1'b0;
      wait_drain();

      // Back-to-back A,B,C with valid held; C lands on the cycle after the GAP->START drain
      repeat (5) @(negedge mon_clk);
      starts.delete();
      send(40'h12_3456_789A, 40'h12_3456_789A, ta);
      send(40'hFE_DCBA_9876, 40'hFE_DCBA_9876, tb);
      send(40'h5A_A55A_A55A, 40'h5A_A55A_A55A, tc);
      @(negedge mon_clk);
      bus0.in_valid = 1'b0;
      check("C_pending", 64'(pending), 64'(1));
      wait_drain();
      check("b2b_B_accept", 64'(tb), 64'(ta + 2));
      check("b2b_start_count", 64'(starts.size()), 64'(3));
      if (starts.size() == 3) begin
         check("b2b_A_latency", 64'(starts[0]), 64'(ta + 2));
         check("b2b_period_AB", 64'(starts[1] - starts[0]), 64'(50));
         check("b2b_period_BC", 64'(starts[2] - starts[1]), 64'(50));
         check("C_accept_at_drain", 64'(tc), 64'(starts[1]));
      end

      // Reset mid-DATA aborts the packet
      send(40'h00_0000_0000, 40'h00_0000_0000, ta);
      @(negedge mon_clk);
      bus0.in_valid = 1'b0;
      repeat (10) @(negedge mon_clk);
      check("pre_reset_data0", 64'(from_mon), 64'(0));
      #2 rst = 1'b1;
      #1;
      check("async_rst_from_mon", 64'(from_mon), 64'(1));
      check("async_rst_busy", 64'(busy), 64'(0));
      check("async_rst_pending", 64'(pending), 64'(0));
      sb.delete();
      @(negedge mon_clk);
      #2 rst = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge mon_clk);
         check("post_rst_line", 64'(from_mon), 64'(1));
         check("post_rst_busy", 64'(busy), 64'(0));
      end
      check("post_rst_in_ready", 64'(bus0.in_ready), 64'(1));

      // GAP=1 instance: one idle bit between stop and next start, 43-cycle period
      @(negedge mon_clk);
      bus1.in_valid = 1'b1;
      bus1.in_data  = 40'h3C_0F0F_F0F0;
      @(negedge mon_clk);
      bus1.in_data  = 40'hC3_F0F0_0F0F;
      n = 0;
      while (!bus1.in_ready && n < 200) begin
         @(negedge mon_clk);
         n++;
      end
      check("g1_second_accept", 64'(bus1.in_ready), 64'(1));
      @(negedge mon_clk);
      bus1.in_valid = 1'b0;
      n = 0;
      while (!tx_done1 && n < 200) begin
         @(negedge mon_clk);
         n++;
      end
      check("g1_first_stop", 64'(tx_done1), 64'(1));
      t1 = cyc;
      @(negedge mon_clk);
      check("g1_gap_bit", 64'(from_mon1), 64'(1));
      @(negedge mon_clk);
      check("g1_next_start", 64'(from_mon1), 64'(0));
      n = 0;
      while (!tx_done1 && n < 200) begin
         @(negedge mon_clk);
         n++;
      end
      check("g1_period", 64'(cyc - t1), 64'(43));

      // Loopback: random words with random valid gaps
      for (int i = 0; i < 1000; i++) begin
         for (int unsigned k = 0; k < $urandom_range(0, 3); k++) begin
            @(negedge mon_clk);
            bus0.in_valid = 1'b0;
            bus0.in_data  = {$urandom, $urandom};
         end
         w = {$urandom, $urandom};
         send(w, w, ta);
      end
      @(negedge mon_clk);
      bus0.in_valid = 1'b0;
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
      $fatal(1, "timeout");
   end
endmodule
